// File: rtl/keccak_pkg.sv
// Shared definitions for the slice-serial permutation stages (chi, iota).
// Holds the slice geometry, the slice type and the chi stage FSM encoding.
package keccak_pkg;

  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam int ROWS       = 5;

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } chi_state_e;

  // Bit position of lane (x, y) inside a 25-bit slice.
  function automatic int bit_idx(input int x, input int y);
    return ROWS * y + x;
  endfunction

endpackage

// File: rtl/chi_row.sv
// Combinational chi on one 5-bit row: b[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
module chi_row
  import keccak_pkg::*;
(
  input  logic [ROWS-1:0] a_i,
  output logic [ROWS-1:0] b_o
);

  for (genvar x = 0; x < ROWS; x++) begin : g_bit
    assign b_o[x] = a_i[x] ^ (~a_i[(x + 1) % ROWS] & a_i[(x + 2) % ROWS]);
  end

endmodule

// File: rtl/chi_stage.sv
// Chi step: walks the slice memory once per start, applies chi to each slice and
// writes it back to the same address one cycle after the read, then pulses done.
module chi_stage
  import keccak_pkg::*;
#(
  parameter int SLICES = 64,
  parameter int AW     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] mem_rd_data,
  output logic [AW-1:0]      mem_rd_addr,
  output logic               mem_wr_en,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [SLICE_W-1:0] mem_wr_data,
  output logic               busy,
  output logic               done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SLICES - 1);

  chi_state_e    state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  slice_t        slice_q, slice_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_en_q, wr_en_d;
  slice_t        chi_slice;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next value from the same pre-edge snapshot of the design.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      slice_q   <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      slice_q   <= slice_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    slice_d   = slice_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          rd_cnt_d = '0;
        end
      end
      ST_RUN: begin
        slice_d   = mem_rd_data;
        wr_addr_d = rd_cnt_q;
        wr_en_d   = 1'b1;
        rd_cnt_d  = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_ADDR) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  for (genvar y = 0; y < ROWS; y++) begin : g_row
    chi_row u_chi_row (
      .a_i(slice_q[bit_idx(0, y) +: ROWS]),
      .b_o(chi_slice[bit_idx(0, y) +: ROWS])
    );
  end

  assign mem_rd_addr = rd_cnt_q;
  // A write landing in the same cycle as reset is dropped with the aborted pass.
  assign mem_wr_en   = wr_en_q & ~rst;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = chi_slice;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_chi_stage.sv
// Scoreboard bench for chi_stage: a behavioural slice memory, a golden chi model,
// expected writes queued at launch and popped as the DUT writes back.
module tb_chi_stage;

  localparam int N = 64;

  typedef struct packed {
    logic [5:0]  addr;
    logic [24:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [24:0] mem_rd_data;
  logic [5:0]  mem_rd_addr;
  logic        mem_wr_en;
  logic [5:0]  mem_wr_addr;
  logic [24:0] mem_wr_data;
  logic        busy;
  logic        done;

  logic [24:0] mem [N];
  logic [24:0] img [N];
  logic        load = 1'b0;

  wr_t sb[$];
  int  done_log[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  chk_offset = 1'b0;

  chi_stage #(.SLICES(64), .AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_rd_data(mem_rd_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_rd_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  function automatic logic [24:0] chi_ref(input logic [24:0] a);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (done) done_log.push_back(cyc);
    if (mem_wr_en) begin
      check("wr_busy", 32'(busy), 32'd1);
      if (chk_offset) check("rd_wr_offset", 32'(mem_rd_addr), 32'(6'(mem_wr_addr + 6'd1)));
      if (sb.size() == 0) begin
        check("sb_extra_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_mem();
    @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic push_expect(input int n_addr);
    for (int i = 0; i < n_addr; i++) sb.push_back(wr_t'{addr: 6'(i), data: chi_ref(mem[i])});
  endtask

  task automatic wait_done(input int n_pulses, input int budget);
    for (int i = 0; i < budget && done_log.size() < n_pulses; i++) tick();
    if (done_log.size() < n_pulses) check("done_timeout", 32'(done_log.size()), 32'(n_pulses));
  endtask

  task automatic run_pass(input string tag);
    int t0;
    push_expect(N);
    done_log.delete();
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    tick();
    check({tag, "_busy_t1"}, 32'(busy), 32'd1);
    check({tag, "_rdaddr_t1"}, 32'(mem_rd_addr), 32'd0);
    wait_done(1, 150);
    if (done_log.size() > 0) check({tag, "_done_cycle"}, 32'(done_log[0]), 32'(t0 + 66));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_log.size()), 32'd1);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    for (int i = 0; i < N; i++) img[i] = '0;
    repeat (2) @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    tick();
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_wr_en", 32'(mem_wr_en), 32'd0);

    // All-zero state.
    run_pass("zeros");

    // All-ones state.
    for (int i = 0; i < N; i++) img[i] = 25'h1FFFFFF;
    load_mem();
    run_pass("ones");

    // Single set bits in slices 5 and 9.
    for (int i = 0; i < N; i++) img[i] = '0;
    img[5] = 25'h0000001;
    img[9] = 25'h0000002;
    load_mem();
    run_pass("sparse");
    check("sparse_mem5", 32'(mem[5]), 32'h0000009);
    check("sparse_mem9", 32'(mem[9]), 32'h0000012);
    check("sparse_mem0", 32'(mem[0]), 32'h0000000);

    // start held for 80 cycles: one pass, then a second launched at T+67.
    for (int i = 0; i < N; i++) img[i] = 25'($urandom);
    load_mem();
    push_expect(N);
    for (int i = 0; i < N; i++) sb.push_back(wr_t'{addr: 6'(i), data: chi_ref(chi_ref(mem[i]))});
    done_log.delete();
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    repeat (80) @(posedge clk);
    #1 start = 1'b0;
    wait_done(2, 120);
    if (done_log.size() > 1) begin
      check("hold_done1_cycle", 32'(done_log[0]), 32'(t0 + 66));
      check("hold_done2_cycle", 32'(done_log[1]), 32'(t0 + 133));
    end
    repeat (10) tick();
    check("hold_done_count", 32'(done_log.size()), 32'd2);
    check("hold_sb_drained", 32'(sb.size()), 32'd0);
    check("hold_idle_busy", 32'(busy), 32'd0);

    // Reset for one cycle at T+30 aborts the pass after address 27.
    for (int i = 0; i < N; i++) img[i] = 25'($urandom);
    load_mem();
    push_expect(28);
    done_log.delete();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (70) tick();
    check("abort_no_done", 32'(done_log.size()), 32'd0);
    check("abort_sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < N; i++)
      check("abort_mem", 32'(mem[i]), 32'((i < 28) ? chi_ref(img[i]) : img[i]));
    run_pass("post_abort");

    // Random state with read/write address offset checking.
    for (int i = 0; i < N; i++) img[i] = 25'($urandom);
    load_mem();
    chk_offset = 1'b1;
    run_pass("random");
    chk_offset = 1'b0;
    for (int i = 0; i < N; i++) check("random_mem", 32'(mem[i]), 32'(chi_ref(img[i])));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
